// File: rtl/mole_game_ctrl_pkg.sv
// Shared definitions for the Whack-a-Mole game engine: state encoding,
// default timing constants and the hole-index width helper.
package mole_game_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_UP   = 3'd2,
    ST_HIT  = 3'd3,
    ST_OVER = 3'd4
  } mole_state_e;

  localparam int unsigned DEF_NUM_HOLES  = 4;
  localparam int unsigned DEF_TICK_DIV   = 1_000_000;
  localparam int unsigned DEF_UP_TICKS   = 80;
  localparam int unsigned DEF_DOWN_TICKS = 50;
  localparam int unsigned DEF_HIT_TICKS  = 20;
  localparam int unsigned DEF_LIVES      = 3;
  localparam int unsigned DEF_SCORE_W    = 8;
  localparam logic [7:0]  DEF_LFSR_SEED  = 8'hA5;

  // Hole index width, shared with the display side.
  function automatic int unsigned hole_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mole_game_ctrl_lfsr.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, with enable.
module mole_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
  end

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-Mole game-state engine: hole selection, phase timing, hit/miss
// detection, score/lives tracking. All outputs are registered.
module mole_game_ctrl
  import mole_game_ctrl_pkg::*;
#(
  parameter int unsigned NUM_HOLES  = DEF_NUM_HOLES,
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned UP_TICKS   = DEF_UP_TICKS,
  parameter int unsigned DOWN_TICKS = DEF_DOWN_TICKS,
  parameter int unsigned HIT_TICKS  = DEF_HIT_TICKS,
  parameter int unsigned LIVES      = DEF_LIVES,
  parameter int unsigned SCORE_W    = DEF_SCORE_W,
  parameter logic [7:0]  LFSR_SEED  = DEF_LFSR_SEED
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_HOLES-1:0]           btn,
  output logic                           mole_visible,
  output logic [hole_w(NUM_HOLES)-1:0]   mole_hole,
  output logic                           mole_hit,
  output logic [SCORE_W-1:0]             score,
  output logic [$clog2(LIVES+1)-1:0]     lives,
  output logic                           hit_pulse,
  output logic                           miss_pulse,
  output logic                           game_over
);

  localparam int unsigned HW = hole_w(NUM_HOLES);
  localparam int unsigned LW = $clog2(LIVES + 1);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TW = $clog2(max3(UP_TICKS, DOWN_TICKS, HIT_TICKS) + 1);

  mole_state_e state, state_n;

  logic [NUM_HOLES-1:0] btn_q, btn_edge;
  logic                 start_q, start_edge;
  logic [PW-1:0]        presc;
  logic                 tick;
  logic [TW-1:0]        timer, timer_load;
  logic                 expire;
  logic [7:0]           lfsr;
  logic [HW-1:0]        cand, hole_n;
  logic [SCORE_W-1:0]   score_n;
  logic [LW-1:0]        lives_n;
  logic                 hit_n, miss_n;
  logic                 unused_lfsr;

  mole_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .q     (lfsr)
  );

  assign cand        = lfsr[HW-1:0];
  assign unused_lfsr = ^lfsr[7:HW];
  assign btn_edge    = btn & ~btn_q;
  assign start_edge  = start & ~start_q;
  assign tick        = (presc == PW'(TICK_DIV - 1));
  assign expire      = tick && (timer == TW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    score_n = score;
    lives_n = lives;
    hole_n  = mole_hole;
    hit_n   = 1'b0;
    miss_n  = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          state_n = ST_WAIT;
          score_n = '0;
          lives_n = LW'(LIVES);
        end
      end
      ST_WAIT: begin
        if (expire) begin
          state_n = ST_UP;
          // Bump a repeated candidate to the next hole; wraps since NUM_HOLES is 2^HW.
          hole_n  = (cand == mole_hole) ? cand + HW'(1) : cand;
        end
      end
      ST_UP: begin
        if (btn_edge[mole_hole]) begin
          state_n = ST_HIT;
          hit_n   = 1'b1;
          if (score != '1) score_n = score + SCORE_W'(1);
        end else if ((|btn_edge) || expire) begin
          miss_n  = 1'b1;
          lives_n = lives - LW'(1);
          state_n = (lives_n == '0) ? ST_OVER : ST_WAIT;
        end
      end
      ST_HIT: begin
        if (expire) state_n = ST_WAIT;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    timer_load = '0;
    case (state_n)
      ST_WAIT: timer_load = TW'(DOWN_TICKS);
      ST_UP:   timer_load = TW'(UP_TICKS);
      ST_HIT:  timer_load = TW'(HIT_TICKS);
      default: timer_load = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q        <= '0;
      start_q      <= 1'b0;
      presc        <= '0;
      timer        <= '0;
      mole_visible <= 1'b0;
      mole_hole    <= '0;
      mole_hit     <= 1'b0;
      score        <= '0;
      lives        <= LW'(LIVES);
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      btn_q   <= btn;
      start_q <= start;
      if (state_n != state) begin
        presc <= '0;
        timer <= timer_load;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick && (timer != '0)) timer <= timer - TW'(1);
      end
      mole_visible <= (state_n == ST_UP) || (state_n == ST_HIT);
      mole_hit     <= (state_n == ST_HIT);
      game_over    <= (state_n == ST_OVER);
      mole_hole    <= hole_n;
      score        <= score_n;
      lives        <= lives_n;
      hit_pulse    <= hit_n;
      miss_pulse   <= miss_n;
    end
  end

endmodule
